axi4_mem_slave: RTL and testbench

- Parametrised AXI4 memory slave: full-protocol successor of the single-beat bus slave.
- Independent write (AW/W/B) and read (AR/R) channels, each with its own FSM.
- Supports FIXED/INCR/WRAP bursts up to 256 beats, byte strobes, narrow sizes and ID echo.
- Sits behind the interconnect as the on-chip scratch RAM target for verification and SoC bring-up.

---
 rtl/axi4_pkg.sv | 22 ++
 rtl/axi4_mem_slave_if.sv | 67 ++++++
 rtl/axi4_burst_addr.sv | 39 +++
 rtl/axi4_mem_slave.sv | 194 +++++++++++++++++++
 tb/tb_axi4_mem_slave.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared burst, response and FSM state types for the AXI4 scratch-RAM slave.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} write_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         read_state_t;

    function automatic logic f_wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_mem_slave_if.sv
// AXI4 write/read channel bundle; slave modport faces the memory, master faces the initiator.
interface axi4_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 11
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   dw_data;
    logic [DATA_WIDTH/8-1:0] dw_strb;
    logic                    dw_last;
    logic                    dw_valid;
    logic                    dw_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     dr_id;
    logic [DATA_WIDTH-1:0]   dr_data;
    logic [1:0]              dr_resp;
    logic                    dr_last;
    logic                    dr_valid;
    logic                    dr_ready;

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  dw_data, dw_strb, dw_last, dw_valid,
        output dw_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output dr_id, dr_data, dr_resp, dr_last, dr_valid,
        input  dr_ready
    );

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output dw_data, dw_strb, dw_last, dw_valid,
        input  dw_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  dr_id, dr_data, dr_resp, dr_last, dr_valid,
        output dr_ready
    );

endinterface

// File: rtl/axi4_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP; illegal bursts fall back to INCR.
module axi4_burst_addr
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 1024
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]            i_size,
    input  logic [7:0]            i_len,
    input  logic [1:0]            i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_wrap_err
);

    localparam logic [ADDR_WIDTH-1:0] MEM_TOP = ADDR_WIDTH'(MEM_BYTES);

    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_sum;
    logic [ADDR_WIDTH-1:0] w_mask;

    assign o_wrap_err = (i_burst == WRAP) && !f_wrap_len_ok(i_len);
    assign w_incr     = ADDR_WIDTH'(1) << i_size;
    assign w_sum      = i_addr + w_incr;
    assign w_mask     = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);

    always_comb begin
        o_next_addr = w_sum;
        if (i_burst == FIXED) begin
            o_next_addr = i_addr;
        end else if ((i_burst == WRAP) && !o_wrap_err) begin
            o_next_addr = (i_addr & ~w_mask) | (w_sum & w_mask);
        end else if ((i_addr < MEM_TOP) && (w_sum >= MEM_TOP)) begin
            // in-range INCR bursts roll over the end of the RAM back to its base
            o_next_addr = w_sum - MEM_TOP;
        end
    end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 scratch-RAM slave: write FSM W_IDLE->W_DATA->W_RESP, read FSM R_IDLE->R_DATA,
// both fully independent and sharing only the byte-strobed memory array.
module axi4_mem_slave
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 11,
    parameter int DEPTH      = 256
) (
    input  logic             clk,
    input  logic             rst,
    axi4_mem_slave_if.slave  bus
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int OFF       = $clog2(BYTES);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int MEM_BYTES = DEPTH * BYTES;
    localparam logic [ADDR_WIDTH-1:0] MEM_TOP = ADDR_WIDTH'(MEM_BYTES);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    write_state_t          r_wstate;
    logic                  r_aw_ready, r_dw_ready, r_b_valid;
    logic [ID_WIDTH-1:0]   r_b_id, r_w_id;
    logic [1:0]            r_b_resp;
    logic [ADDR_WIDTH-1:0] r_w_addr;
    logic [7:0]            r_w_len, r_w_beat;
    logic [2:0]            r_w_size;
    logic [1:0]            r_w_burst;
    logic                  r_w_oob, r_w_last_err;

    logic [ADDR_WIDTH-1:0] w_w_next, w_w_idx_full;
    logic [IDX_W-1:0]      w_w_idx;
    logic                  w_w_wrap_err, w_w_final, w_w_last_bad, w_w_err, w_mem_we;

    read_state_t           r_rstate;
    logic                  r_ar_ready, r_dr_valid, r_dr_last;
    logic [ID_WIDTH-1:0]   r_dr_id;
    logic [ADDR_WIDTH-1:0] r_r_addr;
    logic [7:0]            r_r_len, r_r_beat;
    logic [2:0]            r_r_size;
    logic [1:0]            r_r_burst;
    logic                  r_r_oob;

    logic [ADDR_WIDTH-1:0] w_r_next, w_r_idx_full;
    logic [IDX_W-1:0]      w_r_idx;
    logic                  w_r_wrap_err, w_r_err;

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_BYTES(MEM_BYTES)) u_waddr (
        .i_addr(r_w_addr), .i_size(r_w_size), .i_len(r_w_len), .i_burst(r_w_burst),
        .o_next_addr(w_w_next), .o_wrap_err(w_w_wrap_err)
    );

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_BYTES(MEM_BYTES)) u_raddr (
        .i_addr(r_r_addr), .i_size(r_r_size), .i_len(r_r_len), .i_burst(r_r_burst),
        .o_next_addr(w_r_next), .o_wrap_err(w_r_wrap_err)
    );

    assign w_w_idx_full = (r_w_addr >> OFF) % ADDR_WIDTH'(DEPTH);
    assign w_w_idx      = w_w_idx_full[IDX_W-1:0];
    assign w_w_final    = (r_w_beat == r_w_len);
    assign w_w_last_bad = (bus.dw_last != w_w_final);
    assign w_w_err      = (r_w_size > 3'(OFF)) || (r_w_burst == 2'b11) || w_w_wrap_err
                          || r_w_oob || r_w_last_err;
    assign w_mem_we     = (r_wstate == W_DATA) && bus.dw_valid && !r_w_oob;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate     <= W_IDLE;
            r_aw_ready   <= 1'b1;
            r_dw_ready   <= 1'b0;
            r_b_valid    <= 1'b0;
            r_b_id       <= '0;
            r_b_resp     <= RESP_OKAY;
            r_w_id       <= '0;
            r_w_addr     <= '0;
            r_w_len      <= '0;
            r_w_size     <= '0;
            r_w_burst    <= '0;
            r_w_beat     <= '0;
            r_w_oob      <= 1'b0;
            r_w_last_err <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: if (bus.aw_valid) begin
                    r_w_id       <= bus.aw_id;
                    r_w_addr     <= bus.aw_addr;
                    r_w_len      <= bus.aw_len;
                    r_w_size     <= bus.aw_size;
                    r_w_burst    <= bus.aw_burst;
                    r_w_oob      <= (bus.aw_addr >= MEM_TOP);
                    r_w_beat     <= '0;
                    r_w_last_err <= 1'b0;
                    r_aw_ready   <= 1'b0;
                    r_dw_ready   <= 1'b1;
                    r_wstate     <= W_DATA;
                end
                W_DATA: if (bus.dw_valid) begin
                    r_w_addr <= w_w_next;
                    r_w_beat <= r_w_beat + 8'd1;
                    // the beat count ends the burst; dw_last only contributes to the response
                    if (w_w_final) begin
                        r_dw_ready <= 1'b0;
                        r_b_valid  <= 1'b1;
                        r_b_id     <= r_w_id;
                        r_b_resp   <= (w_w_err || w_w_last_bad) ? RESP_SLVERR : RESP_OKAY;
                        r_wstate   <= W_RESP;
                    end else begin
                        r_w_last_err <= r_w_last_err | w_w_last_bad;
                    end
                end
                W_RESP: if (bus.b_ready) begin
                    r_b_valid  <= 1'b0;
                    r_aw_ready <= 1'b1;
                    r_wstate   <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.dw_strb[i]) r_mem[w_w_idx][8*i +: 8] <= bus.dw_data[8*i +: 8];
            end
        end
    end

    assign w_r_idx_full = (r_r_addr >> OFF) % ADDR_WIDTH'(DEPTH);
    assign w_r_idx      = w_r_idx_full[IDX_W-1:0];
    assign w_r_err      = (r_r_size > 3'(OFF)) || (r_r_burst == 2'b11) || w_r_wrap_err || r_r_oob;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate   <= R_IDLE;
            r_ar_ready <= 1'b1;
            r_dr_valid <= 1'b0;
            r_dr_last  <= 1'b0;
            r_dr_id    <= '0;
            r_r_addr   <= '0;
            r_r_len    <= '0;
            r_r_size   <= '0;
            r_r_burst  <= '0;
            r_r_beat   <= '0;
            r_r_oob    <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: if (bus.ar_valid) begin
                    r_dr_id    <= bus.ar_id;
                    r_r_addr   <= bus.ar_addr;
                    r_r_len    <= bus.ar_len;
                    r_r_size   <= bus.ar_size;
                    r_r_burst  <= bus.ar_burst;
                    r_r_oob    <= (bus.ar_addr >= MEM_TOP);
                    r_r_beat   <= '0;
                    r_dr_last  <= (bus.ar_len == 8'd0);
                    r_dr_valid <= 1'b1;
                    r_ar_ready <= 1'b0;
                    r_rstate   <= R_DATA;
                end
                R_DATA: if (bus.dr_ready) begin
                    if (r_dr_last) begin
                        r_dr_valid <= 1'b0;
                        r_dr_last  <= 1'b0;
                        r_ar_ready <= 1'b1;
                        r_rstate   <= R_IDLE;
                    end else begin
                        r_r_addr  <= w_r_next;
                        r_r_beat  <= r_r_beat + 8'd1;
                        r_dr_last <= ((r_r_beat + 8'd1) == r_r_len);
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign bus.aw_ready = r_aw_ready;
    assign bus.dw_ready = r_dw_ready;
    assign bus.b_valid  = r_b_valid;
    assign bus.b_id     = r_b_id;
    assign bus.b_resp   = r_b_resp;
    assign bus.ar_ready = r_ar_ready;
    assign bus.dr_valid = r_dr_valid;
    assign bus.dr_last  = r_dr_last;
    assign bus.dr_id    = r_dr_id;
    // an out-of-range burst never touches the array; its beats read as zero
    assign bus.dr_data  = (r_dr_valid && !r_r_oob) ? r_mem[w_r_idx] : '0;
    assign bus.dr_resp  = (r_dr_valid && w_r_err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: bursts, strobes, back-pressure, errors and mid-burst reset.
module tb_axi4_mem_slave;
    import axi4_pkg::*;

    localparam int DW = 32, AW = 32, IW = 11, DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi4_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi4_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] wdata [16];
    logic [31:0] rdata [16];
    logic        rlast [16];
    logic [1:0]  rresp [16];
    logic [10:0] rid;
    logic [1:0]  bresp;
    logic [10:0] bid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [10:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bt, input logic [3:0] strb,
                      input int bad_last, input bit hold_b);
        @(negedge clk);
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
        bus.aw_size = sz; bus.aw_burst = bt; bus.aw_valid = 1'b1;
        for (int k = 0; k < 50 && !bus.aw_ready; k++) @(negedge clk);
        @(negedge clk);
        bus.aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.dw_data  = wdata[i];
            bus.dw_strb  = strb;
            bus.dw_last  = (i == int'(len)) != (i == bad_last);
            bus.dw_valid = 1'b1;
            for (int k = 0; k < 50 && !bus.dw_ready; k++) @(negedge clk);
            @(negedge clk);
        end
        bus.dw_valid = 1'b0;
        bus.dw_last  = 1'b0;
        for (int k = 0; k < 50 && !bus.b_valid; k++) @(negedge clk);
        check("b_valid_seen", bus.b_valid, 1);
        if (hold_b) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check("b_hold_valid", bus.b_valid, 1);
                check("b_hold_id", bus.b_id, id);
            end
        end
        bresp = bus.b_resp;
        bid   = bus.b_id;
        bus.b_ready = 1'b1;
        @(negedge clk);
        bus.b_ready = 1'b0;
        if (hold_b) check("b_valid_drop", bus.b_valid, 0);
    endtask

    task automatic rd(input logic [10:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bt,
                      input int hold, input logic [31:0] hold_data);
        @(negedge clk);
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
        bus.ar_size = sz; bus.ar_burst = bt; bus.ar_valid = 1'b1;
        for (int k = 0; k < 50 && !bus.ar_ready; k++) @(negedge clk);
        @(negedge clk);
        bus.ar_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            for (int k = 0; k < 50 && !bus.dr_valid; k++) @(negedge clk);
            if (i == 0 && hold > 0) begin
                for (int k = 0; k < hold; k++) begin
                    check("dr_hold_valid", bus.dr_valid, 1);
                    check("dr_hold_data", bus.dr_data, hold_data);
                    check("dr_hold_last", bus.dr_last, (len == 8'd0));
                    @(negedge clk);
                end
            end
            rdata[i] = bus.dr_data;
            rlast[i] = bus.dr_last;
            rresp[i] = bus.dr_resp;
            rid      = bus.dr_id;
            bus.dr_ready = 1'b1;
            @(negedge clk);
            bus.dr_ready = 1'b0;
        end
        check("dr_valid_drop", bus.dr_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_addr [4];
        logic [31:0] wrap_exp  [4];

        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0;
        bus.aw_burst = '0; bus.aw_valid = 1'b0;
        bus.dw_data = '0; bus.dw_strb = '0; bus.dw_last = 1'b0; bus.dw_valid = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0;
        bus.ar_burst = '0; bus.ar_valid = 1'b0;
        bus.dr_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_aw_ready", bus.aw_ready, 1);
        check("rst_ar_ready", bus.ar_ready, 1);
        check("rst_dw_ready", bus.dw_ready, 0);
        check("rst_b_valid", bus.b_valid, 0);
        check("rst_dr_valid", bus.dr_valid, 0);
        check("rst_dr_data", bus.dr_data, 0);
        check("rst_dr_last", bus.dr_last, 0);
        rst = 1'b1;

        // single beat write + read
        wdata[0] = 32'hDEADBEEF;
        wr(11'h5A5, 32'h10, 8'd0, 3'd2, INCR, 4'hF, -1, 1'b0);
        check("t1_bresp", bresp, RESP_OKAY);
        check("t1_bid", bid, 11'h5A5);
        rd(11'h123, 32'h10, 8'd0, 3'd2, INCR, 0, 32'h0);
        check("t1_data", rdata[0], 32'hDEADBEEF);
        check("t1_last", rlast[0], 1);
        check("t1_resp", rresp[0], RESP_OKAY);
        check("t1_rid", rid, 11'h123);

        // INCR burst of four
        for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
        wr(11'd3, 32'h20, 8'd3, 3'd2, INCR, 4'hF, -1, 1'b0);
        check("t2_bresp", bresp, RESP_OKAY);
        rd(11'd4, 32'h20, 8'd3, 3'd2, INCR, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_data%0d", i), rdata[i], 32'(i + 1));
            check($sformatf("t2_last%0d", i), rlast[i], (i == 3));
        end
        rd(11'd5, 32'h2C, 8'd0, 3'd2, INCR, 0, 32'h0);
        check("t2_word2c", rdata[0], 32'd4);

        // WRAP burst of four from 0x0C
        wdata[0] = 32'hA; wdata[1] = 32'hB; wdata[2] = 32'hC; wdata[3] = 32'hD;
        wr(11'd6, 32'h0C, 8'd3, 3'd2, WRAP, 4'hF, -1, 1'b0);
        check("t3_bresp", bresp, RESP_OKAY);
        wrap_addr = '{32'h00, 32'h04, 32'h08, 32'h0C};
        wrap_exp  = '{32'hB, 32'hC, 32'hD, 32'hA};
        for (int i = 0; i < 4; i++) begin
            rd(11'd7, wrap_addr[i], 8'd0, 3'd2, INCR, 0, 32'h0);
            check($sformatf("t3_word%0d", i), rdata[0], wrap_exp[i]);
        end

        // byte strobes
        wdata[0] = 32'hFFFFFFFF;
        wr(11'd8, 32'h40, 8'd0, 3'd2, INCR, 4'hF, -1, 1'b0);
        wdata[0] = 32'h12345678;
        wr(11'd8, 32'h40, 8'd0, 3'd2, INCR, 4'b0101, -1, 1'b0);
        rd(11'd8, 32'h40, 8'd0, 3'd2, INCR, 0, 32'h0);
        check("t4_strb", rdata[0], 32'hFF34FF78);

        // back-pressure on B and R
        wdata[0] = 32'h5555AAAA; wdata[1] = 32'h0F0F0F0F;
        wr(11'h2AB, 32'h50, 8'd1, 3'd2, INCR, 4'hF, -1, 1'b1);
        check("t5_bresp", bresp, RESP_OKAY);
        rd(11'd9, 32'h50, 8'd1, 3'd2, INCR, 5, 32'h5555AAAA);
        check("t5_data1", rdata[1], 32'h0F0F0F0F);
        check("t5_last0", rlast[0], 0);
        check("t5_last1", rlast[1], 1);

        // out-of-range start
        wdata[0] = 32'hBAD0BAD0;
        wr(11'd10, 32'h400, 8'd0, 3'd2, INCR, 4'hF, -1, 1'b0);
        check("t6_bresp", bresp, RESP_SLVERR);
        rd(11'd10, 32'h00, 8'd0, 3'd2, INCR, 0, 32'h0);
        check("t6_mem_kept", rdata[0], 32'hB);
        rd(11'd10, 32'h400, 8'd0, 3'd2, INCR, 0, 32'h0);
        check("t6_rdata", rdata[0], 32'h0);
        check("t6_rresp", rresp[0], RESP_SLVERR);

        // reserved burst type: SLVERR, still behaves as INCR
        wdata[0] = 32'h61; wdata[1] = 32'h62;
        wr(11'd11, 32'h60, 8'd1, 3'd2, 2'b11, 4'hF, -1, 1'b0);
        check("t7_burst3_bresp", bresp, RESP_SLVERR);
        rd(11'd11, 32'h64, 8'd0, 3'd2, INCR, 0, 32'h0);
        check("t7_burst3_data", rdata[0], 32'h62);

        // dw_last early / missing
        wdata[0] = 32'h71; wdata[1] = 32'h72;
        wr(11'd12, 32'h68, 8'd1, 3'd2, INCR, 4'hF, 0, 1'b0);
        check("t7_last_early", bresp, RESP_SLVERR);
        wr(11'd12, 32'h68, 8'd1, 3'd2, INCR, 4'hF, 1, 1'b0);
        check("t7_last_missing", bresp, RESP_SLVERR);

        // oversize read returns data with SLVERR
        rd(11'd13, 32'h20, 8'd0, 3'd3, INCR, 0, 32'h0);
        check("t7_size_data", rdata[0], 32'd1);
        check("t7_size_resp", rresp[0], RESP_SLVERR);

        // FIXED burst keeps only the last beat
        wdata[0] = 32'h7; wdata[1] = 32'h8; wdata[2] = 32'h9;
        wr(11'd14, 32'h70, 8'd2, 3'd2, FIXED, 4'hF, -1, 1'b0);
        check("t8_fixed_bresp", bresp, RESP_OKAY);
        rd(11'd14, 32'h70, 8'd0, 3'd2, INCR, 0, 32'h0);
        check("t8_fixed_data", rdata[0], 32'h9);

        // reset during beat 2 of an 8-beat write
        @(negedge clk);
        bus.aw_id = 11'd15; bus.aw_addr = 32'h80; bus.aw_len = 8'd7;
        bus.aw_size = 3'd2; bus.aw_burst = INCR; bus.aw_valid = 1'b1;
        for (int k = 0; k < 50 && !bus.aw_ready; k++) @(negedge clk);
        @(negedge clk);
        bus.aw_valid = 1'b0;
        bus.dw_data = 32'h11; bus.dw_strb = 4'hF; bus.dw_last = 1'b0; bus.dw_valid = 1'b1;
        for (int k = 0; k < 50 && !bus.dw_ready; k++) @(negedge clk);
        @(negedge clk);
        bus.dw_data = 32'h22;
        rst = 1'b0;
        #1;
        check("t9_aw_ready", bus.aw_ready, 1);
        check("t9_ar_ready", bus.ar_ready, 1);
        check("t9_dw_ready", bus.dw_ready, 0);
        check("t9_b_valid", bus.b_valid, 0);
        check("t9_dr_valid", bus.dr_valid, 0);
        bus.dw_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd(11'd16, 32'h80, 8'd0, 3'd2, INCR, 0, 32'h0);
        check("t9_data", rdata[0], 32'h11);
        check("t9_resp", rresp[0], RESP_OKAY);
        check("t9_last", rlast[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
